// File: rtl/mips_reg_dumper.sv
// rtl/mips_reg_dumper.sv - walks the register file debug port and streams each register as 4 bytes, MSB first
// Optional feature macro: MIPS_DUMP_PC_EN (prefixes the dump with the 4 bytes of pc_in)
module mips_reg_dumper #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
`ifdef MIPS_DUMP_PC_EN
  ,
  input  logic [31:0]       pc_in
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    SEND    = 3'd2,
    DONE    = 3'd3,
    PC_SEND = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        byte_cnt;
  logic [31:0]       shift;

  // The outgoing byte is always the top of the shift register, so it cannot move during a stall.
  assign tx_data  = shift[31:24];
  assign reg_addr = idx;

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx  <= '0;
            busy <= 1'b1;
`ifdef MIPS_DUMP_PC_EN
            shift    <= pc_in;
            byte_cnt <= '0;
            tx_valid <= 1'b1;
            state    <= PC_SEND;
`else
            state    <= READ;
`endif
          end
        end
        READ: begin
          shift    <= reg_data;
          byte_cnt <= '0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND, PC_SEND: begin
          if (tx_ready) begin
            shift    <= {shift[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              tx_valid <= 1'b0;
              if (state == PC_SEND) begin
                state <= READ;
              end else if (idx == LAST_IDX) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                idx   <= idx + ADDR_W'(1);
                state <= READ;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_reg_dumper.sv
// tb/tb_mips_reg_dumper.sv - randomized self-checking bench for mips_reg_dumper against a byte-stream model
module tb_mips_reg_dumper;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
`ifdef MIPS_DUMP_PC_EN
  localparam int PC_BYTES = 4;
`else
  localparam int PC_BYTES = 0;
`endif
  localparam int BASE_DONE = 5 * NUM_REGS + 1 + PC_BYTES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              tx_ready = 1'b0;
  logic              busy, done, tx_valid;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_data;
  logic [7:0]        tx_data;
  logic [31:0]       regs [NUM_REGS];
`ifdef MIPS_DUMP_PC_EN
  logic [31:0]       pc_in = 32'h0;
  logic [31:0]       pc_val = 32'h00400010;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign reg_data = regs[reg_addr];

  mips_reg_dumper #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .ClockIn  (clk),
    .Reset    (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
`ifdef MIPS_DUMP_PC_EN
    ,
    .pc_in    (pc_in)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA5000000 | i;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
  endtask

  // One dump from a start edge; rnd randomizes tx_ready, hold keeps start high,
  // abort_at>0 resets mid-cycle after that many accepted bytes, start_in_done pulses start in DONE.
  task automatic run_dump(input bit rnd, input bit hold, input int abort_at,
                          input bit start_in_done, input string name);
    logic [7:0] got[$];
    logic [7:0] exp[$];
    int k = 1;
    int stalls = 0;
    int done_k = -1;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int exp_idx;
`ifdef MIPS_DUMP_PC_EN
    for (int b = 3; b >= 0; b--) exp.push_back(8'((pc_val >> (8 * b)) & 32'hFF));
    pc_in = pc_val;
`endif
    for (int i = 0; i < NUM_REGS; i++)
      for (int b = 3; b >= 0; b--) exp.push_back(8'((regs[i] >> (8 * b)) & 32'hFF));

    start = 1'b1;
    tx_ready = 1'b0;
    step();
    if (!hold) start = 1'b0;
`ifdef MIPS_DUMP_PC_EN
    pc_in = ~pc_val;
`endif
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end

    while (k < 3000) begin
      if (k == 2) begin
        checks++;
        if (tx_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s first_valid_n2: got %b want 1", name, tx_valid);
        end
      end
      if (prev_stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL %s stall_hold k=%0d: got valid=%b data=%h want valid=1 data=%h",
                   name, k, tx_valid, tx_data, prev_data);
        end
      end
      if (busy === 1'b1 && tx_valid === 1'b0) begin
        exp_idx = (got.size() - PC_BYTES) / 4;
        checks++;
        if (reg_addr !== ADDR_W'(exp_idx)) begin
          errors++;
          $display("FAIL %s read_addr k=%0d: got %0d want %0d", name, k, reg_addr, exp_idx);
        end
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (tx_valid && !tx_ready) stalls++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (abort_at > 0 && got.size() == abort_at) begin
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || reg_addr !== '0) begin
          errors++;
          $display("FAIL %s async_reset_outputs: got busy=%b done=%b valid=%b data=%h addr=%0d want all 0",
                   name, busy, done, tx_valid, tx_data, reg_addr);
        end
        for (int i = 0; i < abort_at; i++) begin
          checks++;
          if (got[i] !== exp[i]) begin
            errors++;
            $display("FAIL %s pre_abort_byte[%0d]: got %h want %h", name, i, got[i], exp[i]);
          end
        end
        return;
      end
      step();
      k++;
    end

    checks++;
    if (done_k != BASE_DONE + stalls) begin
      errors++;
      $display("FAIL %s done_cycle: got N+%0d want N+%0d", name, done_k, BASE_DONE + stalls);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b want 0", name, busy);
    end
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d want %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s byte[%0d]: got %h want %h", name, i, got[i], exp[i]);
      end
    end

    start = start_in_done;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic check_idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s idle: got busy=%b valid=%b done=%b want 0 0 0", name, busy, tx_valid, done);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || reg_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b valid=%b data=%h addr=%0d want all 0",
               busy, done, tx_valid, tx_data, reg_addr);
    end
    step();
    step();
    rst = 1'b0;
    check_idle(10, "post_reset");
  endtask

  task automatic test_full_dump();
    fill_pattern();
    run_dump(1'b0, 1'b0, 0, 1'b0, "full_dump");
  endtask

  task automatic test_backpressure();
    fill_pattern();
    run_dump(1'b1, 1'b0, 0, 1'b0, "backpressure");
    fill_random();
    run_dump(1'b1, 1'b0, 0, 1'b0, "random_regs");
  endtask

  task automatic test_start_hold();
    fill_random();
    run_dump(1'b1, 1'b1, 0, 1'b0, "start_hold");
    check_idle(8, "start_hold");
  endtask

  task automatic test_start_in_done();
    fill_pattern();
    run_dump(1'b0, 1'b0, 0, 1'b1, "start_in_done");
    fill_random();
    run_dump(1'b1, 1'b0, 0, 1'b0, "start_next_cycle");
  endtask

  task automatic test_abort();
    fill_pattern();
    run_dump(1'b0, 1'b0, 37 + PC_BYTES, 1'b0, "abort");
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle(20, "after_abort");
    run_dump(1'b1, 1'b0, 0, 1'b0, "restart");
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_hold();
    test_start_in_done();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
